// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants for the hazard scoreboard: producer latency classes and
// the forward-select encoding used by the ID_to_EX operand muxes.
package hazard_scoreboard_unit_pkg;

  // Result latency classes presented on id_lat_i.
  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;

  // Forward-select encoding: 0 = register file, k = post-EX stage k.
  typedef enum logic [1:0] {
    FW_NONE = 2'd0,
    FW_MEM  = 2'd1,
    FW_WB   = 2'd2
  } fw_sel_e;

  // Clamp a requested latency to the largest value the scoreboard accepts.
  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
    if (lat > max_lat) begin
      return max_lat;
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_sb_entry.sv
// One scoreboard slot: counts pipeline advances until its register's pending
// result becomes forwardable. Loads a new latency on issue, otherwise counts
// down to zero; everything holds while the pipeline is frozen.
module sb_entry
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic [LAT_W-1:0] cnt_o
);

  logic [LAT_W-1:0] cnt_d;
  logic [LAT_W-1:0] cnt_q;

  // Next count: freeze holds, a new producer overrides, otherwise saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {LAT_W{1'b0}}) begin
      cnt_d = cnt_q - LAT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared by reset so no pending result survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {LAT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Per-register pending-result scoreboard plus post-EX producer pipe. Produces
// stall/bubble and operand forward selects for the instruction sitting in ID.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned MAX_LAT   = 4,
  parameter int unsigned LAT_W     = $clog2(MAX_LAT + 1),
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned FWD_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic              id_reg_write_i,
  input  logic [LAT_W-1:0]  id_lat_i,
  input  logic              freeze_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic [FWD_W-1:0]  fwd_a_o,
  output logic [FWD_W-1:0]  fwd_b_o
);

  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);
  localparam logic [FWD_W-1:0] FWD_NONE  = FWD_W'(FW_NONE);

  // Producer pipe: entry 0 is the instruction now in EX.
  logic [FWD_DEPTH-1:0]             pipe_valid_d;
  logic [FWD_DEPTH-1:0]             pipe_valid_q;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] pipe_rd_d;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] pipe_rd_q;

  logic [NUM_REGS-1:0] busy_s;
  logic                hazard_s;
  logic                issue_s;
  logic                wr_s;
  logic [LAT_W-1:0]    lat_sat_s;

  // Youngest matching producer wins, so scan oldest-first and let younger overwrite.
  function automatic logic [FWD_W-1:0] pick_fwd(
    input logic                             used,
    input logic [REG_AW-1:0]                rs,
    input logic [FWD_DEPTH-1:0]             vld,
    input logic [FWD_DEPTH-1:0][REG_AW-1:0] rds
  );
    logic [FWD_W-1:0] sel;
    sel = FWD_NONE;
    if (used && (rs != {REG_AW{1'b0}})) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (vld[k] && (rds[k] == rs)) begin
          sel = FWD_W'(k + 1);
        end else begin
          sel = sel;
        end
      end
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

  // Register 0 is hardwired and never pending.
  assign busy_s[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic [LAT_W-1:0] cnt_w;
    logic             load_w;

    assign load_w = wr_s & (id_rd_addr_i == REG_AW'(r));

    sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .hold_i     (freeze_i),
      .load_i     (load_w),
      .load_val_i (lat_sat_s),
      .cnt_o      (cnt_w)
    );

    assign busy_s[r] = |cnt_w;
  end

  // Hazard detection, freeze > flush > hazard priority, and forward selects.
  always_comb begin
    if (id_lat_i > MAX_LAT_V) begin
      lat_sat_s = MAX_LAT_V;
    end else begin
      lat_sat_s = id_lat_i;
    end

    hazard_s = id_valid_i &
               ((id_rs1_used_i & (id_rs1_addr_i != {REG_AW{1'b0}}) & busy_s[id_rs1_addr_i]) |
                (id_rs2_used_i & (id_rs2_addr_i != {REG_AW{1'b0}}) & busy_s[id_rs2_addr_i]));

    stall_o  = hazard_s & ~flush_i & ~freeze_i;
    bubble_o = (hazard_s | flush_i) & ~freeze_i;
    issue_s  = id_valid_i & ~hazard_s & ~flush_i & ~freeze_i;
    wr_s     = issue_s & id_reg_write_i & (id_rd_addr_i != {REG_AW{1'b0}});

    fwd_a_o = pick_fwd(id_rs1_used_i, id_rs1_addr_i, pipe_valid_q, pipe_rd_q);
    fwd_b_o = pick_fwd(id_rs2_used_i, id_rs2_addr_i, pipe_valid_q, pipe_rd_q);
  end

  // Producer pipe advance: shift toward WB and capture the issuing writer in EX.
  always_comb begin
    pipe_valid_d = pipe_valid_q;
    pipe_rd_d    = pipe_rd_q;
    if (!freeze_i) begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        pipe_valid_d[k] = pipe_valid_q[k-1];
        pipe_rd_d[k]    = pipe_rd_q[k-1];
      end
      pipe_valid_d[0] = wr_s;
      pipe_rd_d[0]    = wr_s ? id_rd_addr_i : {REG_AW{1'b0}};
    end else begin
      pipe_valid_d = pipe_valid_q;
      pipe_rd_d    = pipe_rd_q;
    end
  end

  // Producer pipe registers; reset empties every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_q <= {FWD_DEPTH{1'b0}};
      pipe_rd_q    <= {(FWD_DEPTH*REG_AW){1'b0}};
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_rd_q    <= pipe_rd_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised successor to the combinational forwarding and hazard-detection pair in the 5-stage core. It keeps a per-register pending-result scoreboard with latency countdowns and a post-EX producer pipe. From these it generates stall, bubble and forward-select for the instruction in ID. Variable-latency producers (loads, long memory, future mul/div) are handled by parameter, replacing the fixed one-cycle load-use rule. It sits beside decode; its forward selects are registered by ID_to_EX exactly as today.

## Interface
- NUM_REGS, 32, architectural registers; index 0 never tracked
- REG_AW, 5, register address width
- MAX_LAT, 4, largest accepted result latency
- LAT_W, $clog2(MAX_LAT+1), latency/counter width
- FWD_DEPTH, 2, post-EX stages able to forward (1 = EX/MEM, 2 = MEM/WB)
- FWD_W, $clog2(FWD_DEPTH+1), forward-select width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_addr_i / id_rs2_addr_i  in  REG_AW  source registers
- id_rs1_used_i / id_rs2_used_i  in  1  source actually read
- id_rd_addr_i  in  REG_AW  destination
- id_reg_write_i  in  1  ID instruction writes rd
- id_lat_i  in  LAT_W  result latency: 0 = ALU, 1 = load, up to MAX_LAT
- freeze_i  in  1  global pipeline hold (memory wait)
- flush_i  in  1  kill the ID instruction (redirect)
- stall_o  out  1  hold PC and IF/ID
- bubble_o  out  1  load a NOP into ID/EX
- fwd_a_o / fwd_b_o  out  FWD_W  forward select for rs1/rs2: 0 = register file, k = stage k

## Operation
- cnt[r] (LAT_W) gives the pipeline-advance cycles until r can be forwarded. pipe[0..FWD_DEPTH-1] holds {valid, rd}: pipe[0] is the instruction now in EX.
- hazard = id_valid_i & ((rs1_used & rs1≠0 & cnt[rs1]≠0) | (rs2_used & rs2≠0 & cnt[rs2]≠0)).
- Priority is freeze > flush > hazard.
  - stall_o = hazard & ~flush_i & ~freeze_i.
  - bubble_o = (hazard | flush_i) & ~freeze_i.
  - issue = id_valid_i & ~hazard & ~flush_i & ~freeze_i.
- Forward select for each used source: the smallest k with pipe[k-1].valid & pipe[k-1].rd == rs & rs≠0, plus one. If none matches, 0. The youngest producer wins. Both outputs are combinational and only meaningful when issue=1.
- Per cycle when freeze_i=0:
  - every nonzero cnt decrements by 1;
  - pipe shifts up;
  - pipe[0] <= issue & id_reg_write_i & rd≠0 ? {1,rd} : {0,x}.
- On issue with a write to rd≠0: cnt[rd] <= id_lat_i. This overrides the decrement of the same entry (WAW: the newest producer wins).
- freeze_i=1 holds every cnt and pipe entry. Outputs still evaluate, but stall_o and bubble_o are forced to 0.
- id_lat_i > MAX_LAT saturates to MAX_LAT.

## Timing
- Reset:
  - all cnt = 0 and all pipe valid = 0;
  - stall_o, bubble_o, fwd_a_o and fwd_b_o = 0, given id_valid_i=0.
- Decision latency is 0 cycles: outputs are combinational from the current state.
- Scoreboard and pipe state update one cycle after issue.
- A load (lat 1) issued at cycle t produces a dependent stall at t+1 with one bubble. The dependent issues at t+2 with fwd = 2 (MEM/WB).
- An ALU op (lat 0) produces no stall. A dependent in the next cycle gets fwd = 1.
- Reset asserted mid-stall clears all pending state. No stall survives reset.

## Structure
- Add LAT_ALU=0 and LAT_LOAD=1 to defines.
- Generalise fw_sel_e in defines to FWD_W bits: FW_NONE=0, FW_MEM=1, FW_WB=2.
- One natural sub-module, sb_entry: a single register's saturating load/decrement counter with hold, instanced NUM_REGS-1 times.
- The producer pipe and the priority encoder stay in the top module.
- In riscv_core:
  - this unit replaces forwarding_unit and hazard_detection_unit;
  - IF_pc_write_en = IF_ID_write_en = ~stall_o & ~freeze_i;
  - ID_EX_flush = bubble_o.

## Test plan
- Back-to-back ALU: issue rd=5 lat 0, then rs1=5 → stall_o=0, fwd_a_o=1. The cycle after that, rs2=5 → fwd_b_o=2.
- Load-use: load rd=7 lat 1, then add rs1=7 → one cycle with stall_o=1 and bubble_o=1, then issue with fwd_a_o=2.
- Long latency: rd=9 lat 4, consumer rs2=9 → stall_o high for exactly 4 cycles, then issue with fwd_b_o=0.
- Freeze mid-countdown: rd=9 lat 3, freeze_i held for 5 cycles after the first stall cycle → cnt is held and the total stall is still 3 unfrozen cycles. stall_o and bubble_o are 0 while frozen.
- x0 and WAW: a write to rd=0 lat 4, then rs1=0 → no stall, fwd 0. Then rd=3 lat 4 followed by rd=3 lat 0 → a consumer of r3 does not stall and gets fwd=1.
- Flush plus reset: flush_i during a hazard → bubble_o=1, stall_o=0, no scoreboard write. Then assert rst_n=0 with cnt[4]=2 → after release, a consumer of r4 does not stall.
